// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD entry/display slice.
//   BCD_W      : width of one BCD nibble
//   BCD_MAX    : largest legal BCD code
//   SEG_0..9   : 7-segment patterns, bit0 = a ... bit6 = g, active high
//   SEG_BLANK  : all segments off
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_entry_display_if.sv
// Digit-entry link from the decimal-to-BCD encoder to the entry/display block.
//   bcd_in    : BCD digit, bit 3 = MSB
//   bcd_valid : one-cycle strobe; bcd_in is sampled on the rising clk edge
//               while it is high. There is no ready/back-pressure: the
//               consumer accepts (or rejects and flags) every strobe.
//   clear     : synchronous clear of the entry register and overflow flag;
//               takes priority over a coincident strobe
// master = producer (encoder / testbench), slave = entry/display block.
interface bcd_entry_display_if;
  import bcd_pkg::*;

  logic [BCD_W-1:0] bcd_in;
  logic             bcd_valid;
  logic             clear;

  modport master (output bcd_in, output bcd_valid, output clear);
  modport slave  (input  bcd_in, input  bcd_valid, input  clear);

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder.
//   bcd : 4-bit BCD code
//   seg : segment pattern, bit0 = a ... bit6 = g, active high;
//         codes 10..15 decode to all segments off
module bcd_to_7seg
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_entry_display.sv
// Calculator-style BCD entry register with a multiplexed common-anode
// 7-segment display and leading-zero blanking.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   entry      : digit strobe / clear link (slave side)
//   digit_val  : packed BCD value, nibble 0 = least significant digit
//   seg        : registered segment drive, active high, bit0 = a
//   an         : registered anode select, active low, one-hot-zero
//   overflow   : sticky, a digit was dropped because the register was full
//   invalid    : one-cycle pulse after a strobe carrying a code above 9
module bcd_entry_display
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_entry_display_if.slave      entry,
  output logic [BCD_W*DIGITS-1:0] digit_val,
  output logic [6:0]              seg,
  output logic [DIGITS-1:0]       an,
  output logic                    overflow,
  output logic                    invalid
);

  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]    refresh_cnt;
  logic [IW-1:0]    scan_idx;
  logic [DIGITS-1:0] lit;
  logic [BCD_W-1:0] sel_nib;
  logic             sel_lit;
  logic [6:0]       sel_seg;
  logic             msd_zero;
  logic             code_bad;

  assign msd_zero = (digit_val[BCD_W*DIGITS-1 -: BCD_W] == '0);
  assign code_bad = (entry.bcd_in > BCD_MAX);

  // Entry register. clear wins over a strobe; a bad code never touches the
  // value; a good code shifts in from the right only while the top nibble
  // is still free, otherwise it is dropped and overflow latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_val <= '0;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      invalid <= 1'b0;
      if (entry.clear) begin
        digit_val <= '0;
        overflow  <= 1'b0;
      end else if (entry.bcd_valid) begin
        if (code_bad) begin
          invalid <= 1'b1;
        end else if (msd_zero) begin
          digit_val <= {digit_val[BCD_W*(DIGITS-1)-1:0], entry.bcd_in};
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Free-running refresh divider; the scan index steps on its terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // A nibble is lit when it or any higher nibble is non-zero; nibble 0 is
  // always lit so a zero value still shows a single "0".
  always_comb begin
    logic nz_above;
    nz_above = 1'b0;
    lit      = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_above = nz_above | (digit_val[BCD_W*k +: BCD_W] != '0);
      lit[k]   = nz_above | (k == 0);
    end
  end

  always_comb begin
    sel_nib = '0;
    sel_lit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx == IW'(k)) begin
        sel_nib = digit_val[BCD_W*k +: BCD_W];
        sel_lit = lit[k];
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd (sel_nib),
    .seg (sel_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else if (sel_lit) begin
      an  <= ~(DIGITS'(1) << scan_idx);
      seg <= sel_seg;
    end else begin
      an  <= '1;
      seg <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_bcd_entry_display.sv
module tb_bcd_entry_display;
  localparam int D  = 4;
  localparam int RD = 4;
  localparam int W  = 4 * D;

  typedef struct {
    logic [W-1:0]   val;
    logic           ovf;
    logic           inv;
    logic [D-1:0]   an;
    logic [6:0]     seg;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [W-1:0] digit_val;
  logic [6:0]   seg;
  logic [D-1:0] an;
  logic         overflow;
  logic         invalid;

  bcd_entry_display_if ent ();

  bcd_entry_display #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .entry     (ent.slave),
    .digit_val (digit_val),
    .seg       (seg),
    .an        (an),
    .overflow  (overflow),
    .invalid   (invalid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   m_val;     // entered number as a plain integer
  bit   m_ovf;
  bit   m_inv;
  int   m_edges;   // rising edges since reset release
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int num_digits(input int v);
    int n = 1;
    while (n < D && v >= pow10(n)) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Advance the model across one rising edge with the inputs that were applied.
  task automatic model_edge(input bit v, input logic [3:0] code, input bit clr);
    exp_t e;
    int   idx;
    idx = ((m_edges) / RD) % D;
    if (idx < num_digits(m_val)) begin
      e.an  = ~(D'(1) << idx);
      e.seg = seg_of((m_val / pow10(idx)) % 10);
    end else begin
      e.an  = '1;
      e.seg = 7'h00;
    end
    m_inv = 1'b0;
    if (clr) begin
      m_val = 0;
      m_ovf = 1'b0;
    end else if (v) begin
      if (code > 9) m_inv = 1'b1;
      else if (m_val < pow10(D - 1)) m_val = m_val * 10 + int'(code);
      else m_ovf = 1'b1;
    end
    m_edges++;
    e.val = to_bcd(m_val);
    e.ovf = m_ovf;
    e.inv = m_inv;
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [3:0] code, input bit clr);
    ent.bcd_valid = v;
    ent.bcd_in    = code;
    ent.clear     = clr;
    @(posedge clk);
    model_edge(v, code, clr);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic strobe(input logic [3:0] code);
    step(1'b1, code, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_val"}, 32'(digit_val), 32'h0);
    check({tag, "_rst_an"},  32'(an), 32'hF);
    check({tag, "_rst_seg"}, 32'(seg), 32'h0);
    check({tag, "_rst_ovf"}, 32'(overflow), 32'h0);
    check({tag, "_rst_inv"}, 32'(invalid), 32'h0);
    exp_q.delete();
    m_val = 0; m_ovf = 1'b0; m_inv = 1'b0; m_edges = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("digit_val", 32'(digit_val), 32'(e.val));
      check("overflow",  32'(overflow),  32'(e.ovf));
      check("invalid",   32'(invalid),   32'(e.inv));
      check("an",        32'(an),        32'(e.an));
      check("seg",       32'(seg),       32'(e.seg));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0;
    m_val = 0; m_ovf = 1'b0; m_inv = 1'b0; m_edges = 0;
    ent.bcd_valid = 1'b0; ent.bcd_in = 4'd0; ent.clear = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_reset("init");

    // zero value: only index 0 lit across a full scan
    idle(20);

    // entry 1,2,3,4 then full scan of 1234
    strobe(4'd1); strobe(4'd2); strobe(4'd3); strobe(4'd4);
    idle(20);

    // overflow, second dropped digit, then clear
    strobe(4'd5); idle(2); strobe(4'd6); idle(2);
    step(1'b0, 4'd0, 1'b1);
    idle(3);

    // invalid codes: single, then back-to-back, then valid digit
    strobe(4'hA); idle(2);
    strobe(4'hB); strobe(4'hF); strobe(4'd3); idle(2);

    // clear has priority over a coincident strobe
    step(1'b1, 4'd7, 1'b1);
    step(1'b1, 4'hC, 1'b1);
    idle(2);

    // leading-zero blanking: 0,0,5 then 0
    strobe(4'd0); strobe(4'd0); strobe(4'd5);
    idle(18);
    strobe(4'd0);
    idle(18);

    // reset in mid-scan with a non-zero value and overflow set
    strobe(4'd9); strobe(4'd9); strobe(4'd9);
    idle(5);
    do_reset("mid");
    idle(6);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit clr, v;
      logic [3:0] code;
      clr  = ($urandom_range(0, 19) == 0);
      v    = ($urandom_range(0, 1) == 1);
      code = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                         : 4'($urandom_range(0, 9));
      step(v, code, clr);
    end
    idle(4);

    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
